// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
// data_bus_bridge : routes CPU data accesses to SRAM or the confreg block
// Revision 1.0
// ============================================================================
module data_bus_bridge #(
  parameter logic [15:0] CONF_BASE = 16'hBFAF,
  parameter int          RAM_AW    = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              cpu_dce,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_daddr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dm,
  output logic              ram_ce,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [7:0]        switch,
  output logic [15:0]       led,
  output logic [31:0]       num_data
);

  localparam logic [15:0] C_OFF_LED     = 16'hF000;
  localparam logic [15:0] C_OFF_NUM     = 16'hF010;
  localparam logic [15:0] C_OFF_TIMER   = 16'hE000;
  localparam logic [15:0] C_OFF_SWITCH  = 16'hF020;
  localparam logic [15:0] C_OFF_SCRATCH = 16'hFFEC;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CONF = 2'd1,
    SEL_RAM  = 2'd2
  } sel_t;

  sel_t        sel_q, sel_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] conf_rdata_q, conf_rdata_d;

  logic        conf_hit;
  logic        ram_hit;
  logic        conf_wr;
  logic [15:0] offset;
  logic [31:0] wmask;
  logic [31:0] timer_inc;
  logic [31:0] conf_rd_val;

  always_comb begin
    conf_hit  = cpu_dce && (cpu_daddr[31:16] == CONF_BASE);
    ram_hit   = cpu_dce && !conf_hit;
    conf_wr   = conf_hit && (cpu_we != 4'b0000);
    offset    = cpu_daddr[15:0];
    wmask     = {{8{cpu_we[3]}}, {8{cpu_we[2]}}, {8{cpu_we[1]}}, {8{cpu_we[0]}}};
    timer_inc = timer_q + 32'd1;

    led_d     = led_q;
    num_d     = num_q;
    scratch_d = scratch_q;
    timer_d   = timer_inc;
    // Written TIMER bytes replace the incremented value rather than adding to it.
    if (conf_wr) begin
      case (offset)
        C_OFF_LED:     led_d     = (cpu_din[15:0] & wmask[15:0]) | (led_q & ~wmask[15:0]);
        C_OFF_NUM:     num_d     = (cpu_din & wmask) | (num_q & ~wmask);
        C_OFF_TIMER:   timer_d   = (cpu_din & wmask) | (timer_inc & ~wmask);
        C_OFF_SCRATCH: scratch_d = (cpu_din & wmask) | (scratch_q & ~wmask);
        default:       ;
      endcase
    end

    case (offset)
      C_OFF_LED:     conf_rd_val = {16'h0000, led_q};
      C_OFF_NUM:     conf_rd_val = num_q;
      C_OFF_TIMER:   conf_rd_val = timer_q;
      C_OFF_SWITCH:  conf_rd_val = {24'h000000, switch};
      C_OFF_SCRATCH: conf_rd_val = scratch_q;
      default:       conf_rd_val = 32'h0000_0000;
    endcase

    if (!cpu_dce || (cpu_we != 4'b0000)) begin
      sel_d = SEL_NONE;
    end else if (conf_hit) begin
      sel_d = SEL_CONF;
    end else begin
      sel_d = SEL_RAM;
    end

    conf_rdata_d = (sel_d == SEL_CONF) ? conf_rd_val : conf_rdata_q;

    case (sel_q)
      SEL_RAM:  cpu_dm = ram_dout;
      SEL_CONF: cpu_dm = conf_rdata_q;
      default:  cpu_dm = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      sel_q        <= SEL_NONE;
      led_q        <= 16'h0000;
      num_q        <= 32'h0000_0000;
      timer_q      <= 32'h0000_0000;
      scratch_q    <= 32'h0000_0000;
      conf_rdata_q <= 32'h0000_0000;
    end else begin
      sel_q        <= sel_d;
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  // SRAM strobes stay combinational even during reset.
  assign ram_ce   = ram_hit;
  assign ram_we   = cpu_we & {4{ram_hit}};
  assign ram_addr = cpu_daddr[RAM_AW+1:2];
  assign ram_din  = cpu_din;
  assign led      = led_q;
  assign num_data = num_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// tb_data_bus_bridge : directed + randomized checks against a reference model
// Revision 1.0
// ============================================================================
module tb_data_bus_bridge;

  localparam logic [15:0] C_BASE = 16'hBFAF;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        cpu_dce;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_daddr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dm;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  always #5 clk = ~clk;

  data_bus_bridge #(.CONF_BASE(16'hBFAF), .RAM_AW(16)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (cpu_rst),
    .cpu_dce    (cpu_dce),
    .cpu_we     (cpu_we),
    .cpu_daddr  (cpu_daddr),
    .cpu_din    (cpu_din),
    .cpu_dm     (cpu_dm),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .switch     (switch),
    .led        (led),
    .num_data   (num_data)
  );

  // Behavioural synchronous SRAM driven by the DUT's RAM port.
  logic [31:0] sram [int];
  logic [31:0] sram_tmp;
  initial ram_dout = 32'h0;
  always @(posedge clk) begin
    if (ram_ce) begin
      sram_tmp = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'h0;
      if (ram_we != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (ram_we[i]) sram_tmp[8*i +: 8] = ram_din[8*i +: 8];
        sram[int'(ram_addr)] = sram_tmp;
      end else begin
        ram_dout <= sram_tmp;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_led;
  logic [31:0] m_num, m_timer, m_scratch;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] conf_value(input logic [15:0] off);
    case (off)
      16'hF000: return {16'h0, m_led};
      16'hF010: return m_num;
      16'hE000: return m_timer;
      16'hF020: return {24'h0, switch};
      16'hFFEC: return m_scratch;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic do_cycle(input logic r, input logic d, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] din);
    logic        conf;
    logic        ramacc;
    int          widx;
    logic [31:0] exp_dm;
    logic [31:0] nt;
    logic [31:0] tmp;
    cpu_rst = r; cpu_dce = d; cpu_we = w; cpu_daddr = a; cpu_din = din;
    #1;
    conf   = d && (a[31:16] == C_BASE);
    ramacc = d && !conf;
    widx   = int'(a[17:2]);
    check("ram_ce", {31'h0, ram_ce}, {31'h0, ramacc});
    check("ram_we", {28'h0, ram_we}, ramacc ? {28'h0, w} : 32'h0);
    if (ramacc) begin
      check("ram_addr", {16'h0, ram_addr}, {16'h0, a[17:2]});
      check("ram_din", ram_din, din);
    end
    @(posedge clk);
    exp_dm = 32'h0;
    if (!r && d && w == 4'b0000)
      exp_dm = conf ? conf_value(a[15:0]) : mem_rd(widx);
    if (ramacc && w != 4'b0000)
      ref_mem[widx] = merge(mem_rd(widx), din, w);
    if (r) begin
      m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_scratch = 32'h0;
    end else begin
      nt = m_timer + 32'd1;
      if (conf && w != 4'b0000) begin
        case (a[15:0])
          16'hF000: begin
            tmp   = merge({16'h0, m_led}, din, {2'b00, w[1:0]});
            m_led = tmp[15:0];
          end
          16'hF010: m_num     = merge(m_num, din, w);
          16'hE000: nt        = merge(nt, din, w);
          16'hFFEC: m_scratch = merge(m_scratch, din, w);
          default:  ;
        endcase
      end
      m_timer = nt;
    end
    #1;
    check("cpu_dm", cpu_dm, exp_dm);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num_data", num_data, m_num);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic        d, r;
    logic [31:0] ram_exp;
    cpu_rst = 1'b1; cpu_dce = 1'b0; cpu_we = 4'h0; cpu_daddr = 32'h0; cpu_din = 32'h0;
    switch = 8'h00;
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_scratch = 32'h0;
    @(posedge clk); #1;

    // Reset, 5 idle cycles, then TIMER read sees 5
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rst_dm", cpu_dm, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    check("timer_after_5", cpu_dm, 32'd5);

    // LED partial write then read back
    do_cycle(1'b0, 1'b1, 4'b0011, 32'hBFAF_F000, 32'h1234_ABCD);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_F000, 32'h0);
    check("led_val", {16'h0, led}, 32'h0000_ABCD);
    check("led_rd", cpu_dm, 32'h0000_ABCD);

    // NUM byte-2 write
    do_cycle(1'b0, 1'b1, 4'b1111, 32'hBFAF_F010, 32'h1111_1111);
    do_cycle(1'b0, 1'b1, 4'b0100, 32'hBFAF_F010, 32'h00AA_0000);
    check("num_byte2", num_data, 32'h11AA_1111);

    // RAM then SWITCH back to back
    switch = 8'h5A;
    do_cycle(1'b0, 1'b1, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D);
    check("ram_addr4", {16'h0, ram_addr}, 32'h4);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    check("ram_rd", cpu_dm, 32'hCAFE_F00D);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_F020, 32'h0);
    check("switch_rd", cpu_dm, 32'h0000_005A);
    // Aliased RAM address wraps modulo 2^16 words
    do_cycle(1'b0, 1'b1, 4'b0000, 32'h0004_0010, 32'h0);
    check("ram_wrap", cpu_dm, 32'hCAFE_F00D);

    // TIMER wrap
    do_cycle(1'b0, 1'b1, 4'b1111, 32'hBFAF_E000, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_E000, 32'h0);
    check("timer_wrap", cpu_dm, 32'h0);

    // Reset with a SCRATCH read pending, then unmapped write/read
    do_cycle(1'b0, 1'b1, 4'b1111, 32'hBFAF_FFEC, 32'h5555_AAAA);
    do_cycle(1'b1, 1'b1, 4'b0000, 32'hBFAF_FFEC, 32'h0);
    check("rst_rd", cpu_dm, 32'h0);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_FFEC, 32'h0);
    check("scratch_rst", cpu_dm, 32'h0);
    do_cycle(1'b0, 1'b1, 4'b1111, 32'hBFAF_1234, 32'hDEAD_BEEF);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_1234, 32'h0);
    check("unmapped_rd", cpu_dm, 32'h0);
    check("unmapped_led", {16'h0, led}, 32'h0);
    check("unmapped_num", num_data, 32'h0);
    do_cycle(1'b0, 1'b1, 4'b0011, 32'hBFAF_F020, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'hBFAF_F020, 32'h0);
    check("switch_ro", cpu_dm, 32'h0000_005A);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
      r = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 6) != 0);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 11))
        0: a = 32'hBFAF_F000;
        1: a = 32'hBFAF_F010;
        2: a = 32'hBFAF_E000;
        3: a = 32'hBFAF_F020;
        4: a = 32'hBFAF_FFEC;
        5: a = {16'hBFAF, 16'($urandom)};
        default: begin
          a = {14'($urandom), 14'h0, 2'($urandom_range(0, 7) >> 1), 2'($urandom)};
          a[4:2] = 3'($urandom_range(0, 7));
          if (a[31:16] == C_BASE) a[31] = 1'b0;
        end
      endcase
      do_cycle(r, d, w, a, $urandom);
    end

    ram_exp = mem_rd(4);
    do_cycle(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    check("final_ram", cpu_dm, ram_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
